// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line, internal baud counter.
// Delivers bytes on a held register with a valid/ack handshake and flags framing/overrun errors.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 rx_i,
    input  logic                 byte_ack_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 byte_valid_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o,
    output logic [2:0]           state_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // START is entered one edge after rx_s first reads low, so the start-bit
    // centre (half a bit after the fall reaches rx_s) is one count earlier.
    localparam logic [CNT_W-1:0] START_SAMPLE = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_BITS - 1);

    logic                 sync1;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_i;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            data_o       <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            // A delivery in STOP below overrides this clear at the same edge.
            if (byte_ack_i) begin
                byte_valid_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end

                ST_START: begin
                    if (cnt == START_SAMPLE) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == LAST_CNT) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        cnt       <= '0;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_o       <= shift_reg;
                            byte_valid_o <= 1'b1;
                            overrun_o    <= byte_valid_o && !byte_ack_i;
                            state        <= ST_IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A break or stuck-low line must return high before a new start is accepted.
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (state != ST_IDLE);
    assign state_o = state;

endmodule
